crc_lanes: RTL and testbench
============================

// Module: crc_lanes
// PURPOSE
//  Parametrised multi-lane serial CRC generator/checker, successor to the single-lane CRC7 unit.
//  One CRC register per lane: CRC7 on CMD with LANES=1, or CRC16 on DAT[3:0] with LANES=4.
//  Sits between the SD transceiver shift logic and the command/data line drivers.
//  Adds a bit-enable stall (ivalid), counted unload with done pulse, and optional residue check.
// PARAMETERS
//  CRC_LEN  7      CRC width in bits (>=2)
//  POLY     7'h09  generator polynomial, implicit x^CRC_LEN term omitted (7'h09=CRC7, 16'h1021=CRC16)
//  LANES    1      number of independent serial lanes (1..8)
// PORTS
//  iclk        in   1      clock, all logic on rising edge
//  irst        in   1      synchronous reset, active-high
//  ivalid      in   1      bit strobe: one bit per lane consumed/produced this cycle
//  idata       in   LANES  serial data, MSB-first, lane i on idata[i]
//  iunload     in   1      start shifting the CRC out (sampled in CALC only)
//  icheck      in   1      compare residue to zero (CRC_CHECK_EN only)
//  ocrc        out  LANES  serial CRC out, MSB-first, lane i on ocrc[i]
//  odone       out  1      one-cycle pulse after the last CRC bit has shifted out
//  oerr        out  LANES  per-lane residue nonzero, valid with ochk
//  ochk        out  1      one-cycle pulse: oerr valid
// BEHAVIOUR
//  - Reset: state=CALC, all CRC regs=0, count=0, ocrc=0, odone=0, oerr=0, ochk=0.
//    irst in any state aborts the operation in the same edge; no odone is produced.
//  - CALC, ivalid=1, per lane: fb=idata[i]^crc[CRC_LEN-1];
//    crc <= {crc[CRC_LEN-2:0],1'b0} ^ (fb ? POLY : 0). With ivalid=0, regs hold.
//  - CALC, iunload=1: go to UNLOAD, count=0. If ivalid is also high, that bit is absorbed first.
//  - UNLOAD: ocrc[i]=crc_i[CRC_LEN-1] (combinational from the register); ocrc=0 in other states.
//    On ivalid: crc <= crc<<1 (zero fill), count++. idata and iunload are ignored.
//    If ivalid stays low the state stalls and ocrc holds.
//  - When count reaches CRC_LEN-1 and ivalid=1: return to CALC with regs now all zero; odone=1 next cycle.
//    Back-to-back blocks need no reset.
//  - Unload latency: the MSB appears on ocrc in the first UNLOAD cycle.
//    Exactly CRC_LEN ivalid strobes empty the register.
//  - count width $clog2(CRC_LEN); it never wraps because the exit happens at CRC_LEN-1.
// CONFIGURATION
//  - CRC_CHECK_EN defined:
//    icheck in CALC samples the regs, after any same-cycle ivalid update.
//    Next cycle: oerr[i]=(crc_i!=0), ochk=1 for one cycle; regs cleared to 0.
//    oerr holds until the next check or reset.
//    icheck in UNLOAD is ignored; icheck together with iunload: the check takes priority and unload is not started.
//  - CRC_CHECK_EN undefined: icheck is unused; oerr=0 and ochk=0 constantly; no compare logic.
// STRUCTURE
//  - crc_pkg: CRC7_POLY=7'h09, CRC16_POLY=16'h1021, CRC7_LEN=7, CRC16_LEN=16, state encoding
//    ST_CALC/ST_UNLOAD (1-bit).
//  - Sub-module crc_lane: one shift register with shift/clear/absorb controls.
//    Instantiated LANES times by generate.
//  - The shared FSM, counter and odone/ochk regs live in crc_lanes.
// TESTING
//  1. LANES=1, CRC_LEN=7, POLY=09: CMD0 {01,000000,32'h0}, 40 strobes, unload -> ocrc seq 1001010, odone after bit 7.
//  2. Same config, no reset in between: CMD17 {01,010001,0} -> 0101010;
//     then RESP17 {00,010001,32'h900} -> 0110011.
//  3. LANES=4, CRC_LEN=16, POLY=1021: 512 bytes of 0xFF on each lane (4096 strobes) -> 16'h7FA1 on every lane.
//  4. Stall: random ivalid gaps of 0-3 cycles during CALC and UNLOAD -> CRC identical to test 1.
//     ocrc is stable while stalled.
//  5. irst pulsed after 3 unload bits -> ocrc=0 and no odone.
//     A fresh CMD0 then gives 1001010.
//  6. CRC_CHECK_EN: CMD0 followed by 7'b1001010 (47 bits), icheck -> oerr=0, ochk pulse.
//     One flipped bit -> oerr[0]=1.
//     LANES=4 with lane 2 corrupted -> oerr=4'b0100.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the multi-lane serial CRC block.
// Optional residue checking is enabled by defining CRC_CHECK_EN.
package crc_pkg;

  // Standard SD polynomials, with the implicit x^LEN term omitted.
  localparam int              CRC7_LEN   = 7;
  localparam int              CRC16_LEN  = 16;
  localparam logic [6:0]      CRC7_POLY  = 7'h09;
  localparam logic [15:0]     CRC16_POLY = 16'h1021;

  // CALC absorbs message bits; UNLOAD shifts the remainder out MSB-first.
  typedef enum logic {
    ST_CALC   = 1'b0,
    ST_UNLOAD = 1'b1
  } crc_state_e;

endpackage

// File: rtl/crc_lanes_if.sv
// Bus between the transceiver shift logic and the multi-lane CRC block.
// oerr/ochk carry real values only when CRC_CHECK_EN is defined.
interface crc_lanes_if #(
  parameter int LANES = 1
);
  import crc_pkg::*;

  // Handshake: ivalid is a one-way bit strobe with no ready. Every cycle it
  // is high the block consumes one bit per lane (CALC) or emits one bit per
  // lane (UNLOAD); with ivalid low everything holds. iunload and icheck are
  // single-cycle requests that are always accepted when sampled in CALC.
  logic             ivalid;
  logic [LANES-1:0] idata;
  logic             iunload;
  logic             icheck;
  logic [LANES-1:0] ocrc;
  logic             odone;
  logic [LANES-1:0] oerr;
  logic             ochk;
  crc_state_e       state;   // debug view of the control FSM

  modport master (
    output ivalid, idata, iunload, icheck,
    input  ocrc, odone, oerr, ochk, state
  );

  modport slave (
    input  ivalid, idata, iunload, icheck,
    output ocrc, odone, oerr, ochk, state
  );

endinterface

// File: rtl/crc_lane.sv
// One serial CRC register. absorb folds a data bit into the remainder,
// shift moves the remainder out MSB-first with zero fill, clear empties it.
// With CRC_CHECK_EN defined, nz_o reports a nonzero post-update remainder.
module crc_lane #(
  parameter int                 CRC_LEN = crc_pkg::CRC7_LEN,
  parameter logic [CRC_LEN-1:0] POLY    = crc_pkg::CRC7_POLY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic absorb_i,
  input  logic shift_i,
  input  logic clear_i,
  input  logic data_i,
  output logic msb_o
`ifdef CRC_CHECK_EN
  ,
  output logic nz_o
`endif
);

  logic [CRC_LEN-1:0] crc_q;
  logic [CRC_LEN-1:0] crc_d;
  logic [CRC_LEN-1:0] upd;
  logic               fb;

  // Next remainder: absorb/shift first, then clear overrides so that a
  // check can still see the bit absorbed in the same cycle.
  always_comb begin
    fb  = data_i ^ crc_q[CRC_LEN-1];
    upd = crc_q;
    if (absorb_i) begin
      upd = {crc_q[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY : '0);
    end else if (shift_i) begin
      upd = {crc_q[CRC_LEN-2:0], 1'b0};
    end
    crc_d = clear_i ? '0 : upd;
  end

  // Remainder register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign msb_o = crc_q[CRC_LEN-1];

`ifdef CRC_CHECK_EN
  assign nz_o = |upd;
`endif

endmodule

// File: rtl/crc_lanes.sv
// Multi-lane serial CRC generator/checker: CRC7 on CMD (LANES=1) or
// CRC16 on DAT[3:0] (LANES=4). Shared FSM, unload counter and pulses live
// here; the per-lane registers live in crc_lane.
// Optional feature macro: CRC_CHECK_EN (residue-to-zero check via icheck).
module crc_lanes #(
  parameter int                 CRC_LEN = crc_pkg::CRC7_LEN,
  parameter logic [CRC_LEN-1:0] POLY    = crc_pkg::CRC7_POLY,
  parameter int                 LANES   = 1
) (
  input  logic       iclk,
  input  logic       irst,
  crc_lanes_if.slave bus
);
  import crc_pkg::*;

  localparam int            CW       = $clog2(CRC_LEN);
  // The exit happens on the strobe that sees this value, so count never wraps.
  localparam logic [CW-1:0] LAST_CNT = CW'(CRC_LEN - 1);

  crc_state_e       state_q;
  crc_state_e       state_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             done_q;
  logic             done_d;
  logic             absorb;
  logic             shift;
  logic             clear;
  logic             check_req;
  logic [LANES-1:0] msb;

`ifdef CRC_CHECK_EN
  logic [LANES-1:0] nz;
  logic [LANES-1:0] err_q;
  logic [LANES-1:0] err_d;
  logic             chk_q;
  logic             chk_d;

  assign check_req = bus.icheck;
`else
  logic unused_icheck;

  assign check_req    = 1'b0;
  assign unused_icheck = bus.icheck;
`endif

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= ST_CALC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a check in CALC wins over an unload request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CALC: begin
        if (!check_req && bus.iunload) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (bus.ivalid && (count_q == LAST_CNT)) begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_CALC;
    endcase
  end

  // FSM outputs: lane controls, unload counter and done pulse.
  always_comb begin
    absorb  = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_CALC: begin
        absorb  = bus.ivalid;
        clear   = check_req;
        count_d = '0;
      end
      ST_UNLOAD: begin
        shift = bus.ivalid;
        if (bus.ivalid) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  // Unload counter and done pulse registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // One CRC register per lane, all driven by the shared controls.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    crc_lane #(
      .CRC_LEN (CRC_LEN),
      .POLY    (POLY)
    ) u_lane (
      .clk_i    (iclk),
      .rst_i    (irst),
      .absorb_i (absorb),
      .shift_i  (shift),
      .clear_i  (clear),
      .data_i   (bus.idata[g]),
      .msb_o    (msb[g])
`ifdef CRC_CHECK_EN
      ,
      .nz_o     (nz[g])
`endif
    );
  end

`ifdef CRC_CHECK_EN
  // Residue compare: capture per-lane nonzero flags when a check is taken.
  always_comb begin
    chk_d = (state_q == ST_CALC) && bus.icheck;
    err_d = chk_d ? nz : err_q;
  end

  // Check result registers; oerr holds until the next check.
  always_ff @(posedge iclk) begin
    if (irst) begin
      chk_q <= 1'b0;
      err_q <= '0;
    end else begin
      chk_q <= chk_d;
      err_q <= err_d;
    end
  end

  assign bus.oerr = err_q;
  assign bus.ochk = chk_q;
`else
  assign bus.oerr = '0;
  assign bus.ochk = 1'b0;
`endif

  assign bus.ocrc  = (state_q == ST_UNLOAD) ? msb : '0;
  assign bus.odone = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_crc_lanes.sv
// Bench for crc_lanes: a CRC7 single-lane instance and a CRC16 four-lane
// instance share one clock. Expected remainders come from spec vectors and
// from a polynomial long-division model. Define CRC_CHECK_EN to cover the
// residue check.
module tb_crc_lanes;
  import crc_pkg::*;

  localparam logic [39:0] CMD0   = {2'b01, 6'd0, 32'h0};
  localparam logic [39:0] CMD17  = {2'b01, 6'd17, 32'h0};
  localparam logic [39:0] RESP17 = {2'b00, 6'd17, 32'h900};

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_cmp;
  int   n_err;

  logic [6:0]   a_got;
  logic [255:0] b_msg [4];
  logic [15:0]  b_got [4];

  crc_lanes_if #(.LANES(1)) a_if ();
  crc_lanes_if #(.LANES(4)) b_if ();

  crc_lanes #(
    .CRC_LEN (CRC7_LEN),
    .POLY    (CRC7_POLY),
    .LANES   (1)
  ) u_a (
    .iclk (clk),
    .irst (rst_a),
    .bus  (a_if)
  );

  crc_lanes #(
    .CRC_LEN (CRC16_LEN),
    .POLY    (CRC16_POLY),
    .LANES   (4)
  ) u_b (
    .iclk (clk),
    .irst (rst_b),
    .bus  (b_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Remainder of msg(x) * x^len divided by x^len + poly(x), by long division
  // over a bit list; msg bits n-1..0 are the message, MSB first.
  function automatic logic [31:0] ref_rem(input logic [255:0] msg, input int n,
                                          input int len, input logic [31:0] poly);
    bit          w[$];
    logic [32:0] gen;
    logic [31:0] rem;
    gen = (33'd1 << len) | {1'b0, poly};
    for (int i = n - 1; i >= 0; i--) w.push_back(msg[i]);
    for (int i = 0; i < len; i++) w.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        for (int j = 0; j <= len; j++) w[i + j] = w[i + j] ^ gen[len - j];
      end
    end
    rem = '0;
    for (int j = 0; j < len; j++) rem = {rem[30:0], w[n + j]};
    return rem;
  endfunction

  function automatic logic [255:0] rand_msg();
    logic [255:0] m;
    for (int w = 0; w < 8; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  // ---------------- drivers ----------------
  task automatic a_send(input logic [255:0] msg, input int n, input int max_gap,
                        input bit with_check);
    for (int i = n - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) begin
        a_if.idata = 1'($urandom);
        @(posedge clk); #1;
      end
      a_if.ivalid   = 1'b1;
      a_if.idata[0] = msg[i];
      if (with_check && i == 0) a_if.icheck = 1'b1;
      @(posedge clk); #1;
      a_if.ivalid = 1'b0;
      if (with_check) a_if.icheck = 1'b0;
    end
  endtask

  task automatic a_unload(input int max_gap);
    logic prev;
    bit   early;
    bit   stray;
    early = 1'b0;
    stray = 1'b0;
    a_if.iunload = 1'b1;
    @(posedge clk); #1;
    a_if.iunload = 1'b0;
    n_cmp++;
    if (a_if.state !== ST_UNLOAD) begin
      n_err++;
      $display("FAIL a_enter_unload: got %0d expected %0d", a_if.state, ST_UNLOAD);
    end
    for (int k = 0; k < 7; k++) begin
      prev = a_if.ocrc[0];
      repeat ($urandom_range(0, max_gap)) begin
        a_if.idata = 1'($urandom);
        @(posedge clk); #1;
        n_cmp++;
        if (a_if.ocrc[0] !== prev) begin
          n_err++;
          $display("FAIL a_stall_hold: got %b expected %b", a_if.ocrc[0], prev);
        end
        if (a_if.odone) early = 1'b1;
      end
      a_got[6-k]   = a_if.ocrc[0];
      a_if.ivalid  = 1'b1;
      a_if.idata   = 1'($urandom);
      a_if.icheck  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      a_if.ivalid = 1'b0;
      a_if.icheck = 1'b0;
      if (k < 6 && a_if.odone) early = 1'b1;
      if (a_if.ochk) stray = 1'b1;
    end
    n_cmp++;
    if (a_if.odone !== 1'b1) begin
      n_err++;
      $display("FAIL a_odone: got %b expected 1", a_if.odone);
    end
    n_cmp++;
    if (early || stray) begin
      n_err++;
      $display("FAIL a_unload_spurious: got early=%b ochk=%b expected 0/0", early, stray);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_if.odone !== 1'b0) begin
      n_err++;
      $display("FAIL a_odone_width: got %b expected 0", a_if.odone);
    end
  endtask

  task automatic b_send(input int n, input int max_gap, input bit with_check);
    for (int i = n - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) begin
        b_if.idata = 4'($urandom);
        @(posedge clk); #1;
      end
      b_if.ivalid = 1'b1;
      for (int l = 0; l < 4; l++) b_if.idata[l] = b_msg[l][i];
      if (with_check && i == 0) b_if.icheck = 1'b1;
      @(posedge clk); #1;
      b_if.ivalid = 1'b0;
      if (with_check) b_if.icheck = 1'b0;
    end
  endtask

  task automatic b_unload(input int max_gap);
    logic [3:0] prev;
    bit         early;
    early = 1'b0;
    b_if.iunload = 1'b1;
    @(posedge clk); #1;
    b_if.iunload = 1'b0;
    for (int k = 0; k < 16; k++) begin
      prev = b_if.ocrc;
      repeat ($urandom_range(0, max_gap)) begin
        b_if.idata = 4'($urandom);
        @(posedge clk); #1;
        n_cmp++;
        if (b_if.ocrc !== prev) begin
          n_err++;
          $display("FAIL b_stall_hold: got %h expected %h", b_if.ocrc, prev);
        end
      end
      for (int l = 0; l < 4; l++) b_got[l][15-k] = b_if.ocrc[l];
      b_if.ivalid = 1'b1;
      b_if.idata  = 4'($urandom);
      @(posedge clk); #1;
      b_if.ivalid = 1'b0;
      if (k < 15 && b_if.odone) early = 1'b1;
    end
    n_cmp++;
    if (b_if.odone !== 1'b1 || early) begin
      n_err++;
      $display("FAIL b_odone: got %b early=%b expected 1 early=0", b_if.odone, early);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    n_cmp++;
    if (a_if.state !== ST_CALC || b_if.state !== ST_CALC) begin
      n_err++;
      $display("FAIL reset_state: got %0d/%0d expected 0/0", a_if.state, b_if.state);
    end
    n_cmp++;
    if (a_if.ocrc !== 1'b0 || b_if.ocrc !== 4'h0) begin
      n_err++;
      $display("FAIL reset_ocrc: got %b/%h expected 0/0", a_if.ocrc, b_if.ocrc);
    end
    n_cmp++;
    if (a_if.odone !== 1'b0 || b_if.odone !== 1'b0) begin
      n_err++;
      $display("FAIL reset_odone: got %b/%b expected 0/0", a_if.odone, b_if.odone);
    end
    n_cmp++;
    if (a_if.ochk !== 1'b0 || a_if.oerr !== 1'b0 || b_if.ochk !== 1'b0 || b_if.oerr !== 4'h0) begin
      n_err++;
      $display("FAIL reset_check_out: got %b%b/%b%h expected 00/00",
               a_if.ochk, a_if.oerr, b_if.ochk, b_if.oerr);
    end
  endtask

  task automatic test_cmd0();
    a_send(256'(CMD0), 40, 0, 1'b0);
    a_unload(0);
    n_cmp++;
    if (a_got !== 7'b1001010) begin
      n_err++;
      $display("FAIL cmd0_crc7: got %b expected 1001010", a_got);
    end
  endtask

  task automatic test_back_to_back();
    a_send(256'(CMD17), 40, 0, 1'b0);
    a_unload(0);
    n_cmp++;
    if (a_got !== 7'b0101010) begin
      n_err++;
      $display("FAIL cmd17_crc7: got %b expected 0101010", a_got);
    end
    a_send(256'(RESP17), 40, 0, 1'b0);
    a_unload(0);
    n_cmp++;
    if (a_got !== 7'b0110011) begin
      n_err++;
      $display("FAIL resp17_crc7: got %b expected 0110011", a_got);
    end
  endtask

  task automatic test_stall();
    a_send(256'(CMD0), 40, 3, 1'b0);
    a_unload(3);
    n_cmp++;
    if (a_got !== 7'b1001010) begin
      n_err++;
      $display("FAIL stall_crc7: got %b expected 1001010", a_got);
    end
  endtask

  task automatic test_abort();
    bit seen_done;
    seen_done = 1'b0;
    a_send(256'(CMD0), 40, 0, 1'b0);
    a_if.iunload = 1'b1;
    @(posedge clk); #1;
    a_if.iunload = 1'b0;
    repeat (3) begin
      a_if.ivalid = 1'b1;
      @(posedge clk); #1;
      a_if.ivalid = 1'b0;
    end
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    n_cmp++;
    if (a_if.ocrc !== 1'b0 || a_if.state !== ST_CALC) begin
      n_err++;
      $display("FAIL abort_state: got ocrc=%b state=%0d expected 0/0", a_if.ocrc, a_if.state);
    end
    if (a_if.odone) seen_done = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (a_if.odone) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin
      n_err++;
      $display("FAIL abort_no_done: got odone=1 expected 0");
    end
    a_send(256'(CMD0), 40, 1, 1'b0);
    a_unload(1);
    n_cmp++;
    if (a_got !== 7'b1001010) begin
      n_err++;
      $display("FAIL abort_fresh_cmd0: got %b expected 1001010", a_got);
    end
  endtask

  task automatic test_random_crc7();
    logic [255:0] m;
    logic [6:0]   exp;
    int           n;
    for (int r = 0; r < 16; r++) begin
      m   = rand_msg();
      n   = $urandom_range(8, 120);
      exp = ref_rem(m, n, 7, 32'h09);
      a_send(m, n, 2, 1'b0);
      a_unload(2);
      n_cmp++;
      if (a_got !== exp) begin
        n_err++;
        $display("FAIL rand_crc7[%0d]: got %b expected %b (n=%0d)", r, a_got, exp, n);
      end
    end
  endtask

  task automatic test_crc16_ones();
    b_if.ivalid = 1'b1;
    b_if.idata  = 4'hF;
    repeat (4096) @(posedge clk);
    #1;
    b_if.ivalid = 1'b0;
    b_unload(0);
    for (int l = 0; l < 4; l++) begin
      n_cmp++;
      if (b_got[l] !== 16'h7FA1) begin
        n_err++;
        $display("FAIL crc16_ones lane%0d: got %h expected 7fa1", l, b_got[l]);
      end
    end
  endtask

  task automatic test_random_crc16();
    logic [15:0] exp;
    int          n;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(16, 100);
      for (int l = 0; l < 4; l++) b_msg[l] = rand_msg();
      b_send(n, 2, 1'b0);
      b_unload(2);
      for (int l = 0; l < 4; l++) begin
        exp = ref_rem(b_msg[l], n, 16, 32'h1021);
        n_cmp++;
        if (b_got[l] !== exp) begin
          n_err++;
          $display("FAIL rand_crc16[%0d] lane%0d: got %h expected %h", r, l, b_got[l], exp);
        end
      end
    end
  endtask

`ifdef CRC_CHECK_EN
  task automatic a_check(input logic [255:0] msg, input int n, input logic exp_err,
                         input string name);
    a_send(msg, n, 1, 1'b1);
    n_cmp++;
    if (a_if.ochk !== 1'b1 || a_if.oerr[0] !== exp_err) begin
      n_err++;
      $display("FAIL %s: got ochk=%b oerr=%b expected 1/%b", name, a_if.ochk, a_if.oerr, exp_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_if.ochk !== 1'b0 || a_if.oerr[0] !== exp_err) begin
      n_err++;
      $display("FAIL %s_hold: got ochk=%b oerr=%b expected 0/%b", name, a_if.ochk, a_if.oerr, exp_err);
    end
  endtask

  task automatic test_check_crc7();
    logic [255:0] m;
    logic [6:0]   c;
    int           n;
    int           flip;
    bit           bad;
    a_check(256'({CMD0, 7'b1001010}), 47, 1'b0, "chk_cmd0_good");
    a_check(256'({CMD0, 7'b1001010}) ^ (256'd1 << 20), 47, 1'b1, "chk_cmd0_flip");
    // The check empties the registers, so an immediate unload yields zero.
    a_unload(0);
    n_cmp++;
    if (a_got !== 7'h00) begin
      n_err++;
      $display("FAIL chk_clears_regs: got %b expected 0000000", a_got);
    end
    for (int r = 0; r < 8; r++) begin
      m    = rand_msg();
      n    = $urandom_range(8, 60);
      c    = ref_rem(m, n, 7, 32'h09);
      m    = (m << 7) | 256'(c);
      bad  = 1'($urandom_range(0, 1));
      flip = $urandom_range(0, n + 6);
      if (bad) m = m ^ (256'd1 << flip);
      a_check(m, n + 7, bad, "chk_rand_crc7");
    end
  endtask

  task automatic test_check_priority();
    a_send(rand_msg(), 20, 0, 1'b0);
    a_if.icheck  = 1'b1;
    a_if.iunload = 1'b1;
    @(posedge clk); #1;
    a_if.icheck  = 1'b0;
    a_if.iunload = 1'b0;
    n_cmp++;
    if (a_if.state !== ST_CALC || a_if.ochk !== 1'b1) begin
      n_err++;
      $display("FAIL chk_priority: got state=%0d ochk=%b expected 0/1", a_if.state, a_if.ochk);
    end
  endtask

  task automatic test_check_crc16();
    logic [15:0] c;
    int          n;
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(20, 80);
      for (int l = 0; l < 4; l++) begin
        b_msg[l] = rand_msg();
        c        = ref_rem(b_msg[l], n, 16, 32'h1021);
        b_msg[l] = (b_msg[l] << 16) | 256'(c);
      end
      if (r == 1) b_msg[2] = b_msg[2] ^ (256'd1 << $urandom_range(0, n + 15));
      b_send(n + 16, 1, 1'b1);
      n_cmp++;
      if (b_if.ochk !== 1'b1 || b_if.oerr !== ((r == 1) ? 4'b0100 : 4'b0000)) begin
        n_err++;
        $display("FAIL chk_crc16[%0d]: got ochk=%b oerr=%b expected 1/%b", r, b_if.ochk,
                 b_if.oerr, (r == 1) ? 4'b0100 : 4'b0000);
      end
    end
  endtask
`else
  task automatic test_check_disabled();
    a_if.icheck = 1'b1;
    a_send(256'(CMD0), 40, 1, 1'b0);
    n_cmp++;
    if (a_if.ochk !== 1'b0 || a_if.oerr !== 1'b0) begin
      n_err++;
      $display("FAIL chk_disabled_out: got ochk=%b oerr=%b expected 0/0", a_if.ochk, a_if.oerr);
    end
    a_if.icheck = 1'b0;
    a_unload(0);
    n_cmp++;
    if (a_got !== 7'b1001010) begin
      n_err++;
      $display("FAIL chk_disabled_crc: got %b expected 1001010", a_got);
    end
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_a        = 1'b1;
    rst_b        = 1'b1;
    a_if.ivalid  = 1'b0;
    a_if.idata   = '0;
    a_if.iunload = 1'b0;
    a_if.icheck  = 1'b0;
    b_if.ivalid  = 1'b0;
    b_if.idata   = '0;
    b_if.iunload = 1'b0;
    b_if.icheck  = 1'b0;

    test_reset();
    test_cmd0();
    test_back_to_back();
    test_stall();
    test_abort();
    test_random_crc7();
    test_crc16_ones();
    test_random_crc16();
`ifdef CRC_CHECK_EN
    test_check_crc7();
    test_check_priority();
    test_check_crc16();
`else
    test_check_disabled();
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
